// File: rtl/spi_word_sequencer_if.sv
// rtl/spi_word_sequencer_if.sv - control and byte-master handshake bundle for spi_word_sequencer
interface spi_word_sequencer_if #(
   parameter int NBYTES = 3
);
   logic                  start;
   logic [8*NBYTES-1:0]   word_in;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [7:0]            spi_data;
   logic                  spi_transmit;
   logic                  spi_clr;
   logic                  spi_finish;

   // master: control logic plus the byte master it feeds
   modport master (
      output start, word_in, spi_finish,
      input  busy, done, err, spi_data, spi_transmit, spi_clr
   );

   modport slave (
      input  start, word_in, spi_finish,
      output busy, done, err, spi_data, spi_transmit, spi_clr
   );
endinterface

// File: rtl/spi_word_sequencer.sv
// rtl/spi_word_sequencer.sv - feeds an NBYTES command word to an 8-bit SPI byte master, MSB byte first
module spi_word_sequencer #(
   parameter int NBYTES     = 3,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 16
) (
   input logic                 mainclk_i,
   input logic                 reset_i,
   spi_word_sequencer_if.slave bus
);
   localparam int WW = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [IW-1:0] IDX_LAST  = IW'(NBYTES - 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SEND,
      S_GAP,
      S_NEXT,
      S_ABORT
   } state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   shreg_q, shreg_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [GW-1:0]   gcnt_q, gcnt_d;
   logic            done_q, done_d;

   always_ff @(posedge mainclk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         tcnt_q  <= tcnt_d;
         gcnt_q  <= gcnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      tcnt_d  = tcnt_q;
      gcnt_d  = gcnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               shreg_d = bus.word_in;
               idx_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            tcnt_d  = '0;
            gcnt_d  = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            // a finish already pending on entry counts as completion, not a fault
            if (bus.spi_finish) begin
               state_d = (GAP_CYCLES == 0) ? S_NEXT : S_GAP;
            end else if (tcnt_q == TCNT_LAST) begin
               state_d = S_ABORT;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gcnt_q == GAP_LAST) begin
               state_d = S_NEXT;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end
         S_NEXT: begin
            if (idx_q == IDX_LAST) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               idx_d   = idx_q + 1'b1;
               shreg_d = shreg_q << 8;
               state_d = S_CLEAR;
            end
         end
         S_ABORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // spi_data is the top byte of the shift register, so it only moves on entry to CLEAR
   assign bus.spi_data     = shreg_q[WW-1 -: 8];
   assign bus.spi_clr      = (state_q == S_CLEAR) || (state_q == S_ABORT);
   assign bus.spi_transmit = (state_q == S_SEND);
   assign bus.err          = (state_q == S_ABORT);
   assign bus.done         = done_q;
   assign bus.busy         = (state_q != S_IDLE) && (state_q != S_ABORT);
endmodule

// File: tb/tb_spi_word_sequencer.sv
// tb/tb_spi_word_sequencer.sv - directed self-checking bench for spi_word_sequencer
module tb_spi_word_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spi_word_sequencer_if #(.NBYTES(3)) ba ();
   spi_word_sequencer_if #(.NBYTES(1)) bb ();

   spi_word_sequencer #(.NBYTES(3), .GAP_CYCLES(2), .TIMEOUT(16)) u_a (
      .mainclk_i(clk), .reset_i(rst), .bus(ba)
   );
   spi_word_sequencer #(.NBYTES(1), .GAP_CYCLES(0), .TIMEOUT(16)) u_b (
      .mainclk_i(clk), .reset_i(rst), .bus(bb)
   );

   // behavioural byte masters: 8-cycle LSB-first shift, finish held until cleared
   logic [3:0] ma_cnt, mb_cnt;
   logic       ma_fin, mb_fin;
   bit         ma_stuck = 1'b0;
   bit         ma_bits[$];
   bit         mb_bits[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma_cnt <= '0;
         ma_fin <= 1'b0;
      end else if (ba.spi_clr) begin
         ma_cnt <= '0;
         ma_fin <= 1'b0;
      end else if (ba.spi_transmit && !ma_stuck && ma_cnt < 4'd8) begin
         ma_bits.push_back(ba.spi_data[ma_cnt[2:0]]);
         ma_cnt <= ma_cnt + 4'd1;
         if (ma_cnt == 4'd7) ma_fin <= 1'b1;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mb_cnt <= '0;
         mb_fin <= 1'b0;
      end else if (bb.spi_clr) begin
         mb_cnt <= '0;
         mb_fin <= 1'b0;
      end else if (bb.spi_transmit && mb_cnt < 4'd8) begin
         mb_bits.push_back(bb.spi_data[mb_cnt[2:0]]);
         mb_cnt <= mb_cnt + 4'd1;
         if (mb_cnt == 4'd7) mb_fin <= 1'b1;
      end
   end

   assign ba.spi_finish = ma_fin;
   assign bb.spi_finish = mb_fin;

   // invariant monitor: clr/transmit exclusive, spi_data steady while transmitting
   int         mon_viol = 0;
   logic       pa_tx = 1'b0, pb_tx = 1'b0;
   logic [7:0] pa_d = 8'h00, pb_d = 8'h00;

   always @(negedge clk) begin
      if (!rst && ((ba.spi_clr && ba.spi_transmit) || (bb.spi_clr && bb.spi_transmit) ||
                   (pa_tx && ba.spi_transmit && ba.spi_data !== pa_d) ||
                   (pb_tx && bb.spi_transmit && bb.spi_data !== pb_d)))
         mon_viol <= mon_viol + 1;
      pa_tx <= rst ? 1'b0 : ba.spi_transmit;
      pb_tx <= rst ? 1'b0 : bb.spi_transmit;
      pa_d  <= ba.spi_data;
      pb_d  <= bb.spi_data;
   end

   function automatic logic [23:0] got_word();
      logic [23:0] w = '0;
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 8; i++)
            if (8 * k + i < ma_bits.size()) w[23 - 8 * k - 7 + i] = ma_bits[8 * k + i];
      return w;
   endfunction

   // caller sits at a negedge; returns at the negedge where done is seen (or budget runs out)
   task automatic run_a(input logic [23:0] w, input bit inject,
                        output int done_cyc, output logic busy0, output int n_err);
      int cyc;
      ma_bits.delete();
      ba.word_in = w;
      ba.start   = 1'b1;
      @(negedge clk);
      ba.start   = 1'b0;
      ba.word_in = 24'hFFFFFF;
      busy0    = ba.busy;
      cyc      = 0;
      done_cyc = -1;
      n_err    = 0;
      while (cyc < 200 && done_cyc < 0) begin
         if (ba.err) n_err++;
         if (ba.done) begin
            done_cyc = cyc;
         end else begin
            ba.start = inject && (cyc == 5 || cyc == 20);
            @(negedge clk);
            cyc++;
         end
      end
      ba.start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({ba.busy, ba.done, ba.err, ba.spi_transmit, ba.spi_clr, ba.spi_data} !== 13'h0) begin
         errors++;
         $display("FAIL reset_a_in_reset got=%h want=0",
                  {ba.busy, ba.done, ba.err, ba.spi_transmit, ba.spi_clr, ba.spi_data});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ba.busy, ba.done, ba.err, ba.spi_transmit, ba.spi_clr, ba.spi_data} !== 13'h0) begin
         errors++;
         $display("FAIL reset_a_idle got=%h want=0",
                  {ba.busy, ba.done, ba.err, ba.spi_transmit, ba.spi_clr, ba.spi_data});
      end
      checks++;
      if ({bb.busy, bb.done, bb.err, bb.spi_transmit, bb.spi_clr, bb.spi_data} !== 13'h0) begin
         errors++;
         $display("FAIL reset_b_idle got=%h want=0",
                  {bb.busy, bb.done, bb.err, bb.spi_transmit, bb.spi_clr, bb.spi_data});
      end
   endtask

   task automatic test_basic_word();
      int dc, ne;
      logic b0;
      run_a(24'hA5C33C, 1'b0, dc, b0, ne);
      checks++;
      if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy_after_accept got=%b want=1", b0); end
      checks++;
      if (dc !== 39) begin errors++; $display("FAIL basic_done_cycle got=%0d want=39", dc); end
      checks++;
      if (ne !== 0) begin errors++; $display("FAIL basic_err_count got=%0d want=0", ne); end
      checks++;
      if (ba.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b want=0", ba.busy); end
      checks++;
      if (ma_bits.size() !== 24) begin errors++; $display("FAIL basic_bit_count got=%0d want=24", ma_bits.size()); end
      checks++;
      if (got_word() !== 24'hA5C33C) begin errors++; $display("FAIL basic_bytes got=%h want=a5c33c", got_word()); end
   endtask

   task automatic test_start_ignored();
      int dc, ne, extra_done, busy_seen;
      logic b0;
      @(negedge clk);
      run_a(24'hA5C33C, 1'b1, dc, b0, ne);
      checks++;
      if (dc !== 39) begin errors++; $display("FAIL ignore_done_cycle got=%0d want=39", dc); end
      checks++;
      if (got_word() !== 24'hA5C33C) begin errors++; $display("FAIL ignore_bytes got=%h want=a5c33c", got_word()); end
      extra_done = 0;
      busy_seen  = 0;
      repeat (20) begin
         @(negedge clk);
         if (ba.done) extra_done++;
         if (ba.busy) busy_seen++;
      end
      checks++;
      if (extra_done !== 0) begin errors++; $display("FAIL ignore_extra_done got=%0d want=0", extra_done); end
      checks++;
      if (busy_seen !== 0) begin errors++; $display("FAIL ignore_requeued got=%0d want=0", busy_seen); end
   endtask

   task automatic test_timeout();
      int cyc, err_cyc, late;
      logic clr_at, tx_at, busy_at;
      ma_stuck = 1'b1;
      ba.word_in = 24'h123456;
      ba.start   = 1'b1;
      @(negedge clk);
      ba.start = 1'b0;
      cyc = 0;
      err_cyc = -1;
      clr_at = 1'b0; tx_at = 1'b1; busy_at = 1'b1;
      while (cyc < 100 && err_cyc < 0) begin
         if (ba.err) begin
            err_cyc = cyc;
            clr_at  = ba.spi_clr;
            tx_at   = ba.spi_transmit;
            busy_at = ba.busy;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      checks++;
      if (err_cyc !== 17) begin errors++; $display("FAIL timeout_err_cycle got=%0d want=17", err_cyc); end
      checks++;
      if ({clr_at, tx_at, busy_at} !== 3'b100) begin
         errors++;
         $display("FAIL timeout_abort_outputs clr_tx_busy got=%b want=100", {clr_at, tx_at, busy_at});
      end
      @(negedge clk);
      checks++;
      if ({ba.err, ba.busy} !== 2'b00) begin errors++; $display("FAIL timeout_after got=%b want=00", {ba.err, ba.busy}); end
      late = 0;
      repeat (30) begin
         @(negedge clk);
         if (ba.done || ba.busy) late++;
      end
      checks++;
      if (late !== 0) begin errors++; $display("FAIL timeout_no_done got=%0d want=0", late); end
      ma_stuck = 1'b0;
   endtask

   task automatic test_single_byte_no_gap();
      int cyc, dc;
      logic [7:0] seq;
      mb_bits.delete();
      bb.word_in = 8'h81;
      bb.start   = 1'b1;
      @(negedge clk);
      bb.start   = 1'b0;
      bb.word_in = 8'h00;
      cyc = 0;
      dc  = -1;
      while (cyc < 100 && dc < 0) begin
         if (bb.done) dc = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      checks++;
      if (dc !== 11) begin errors++; $display("FAIL nogap_done_cycle got=%0d want=11", dc); end
      seq = '0;
      foreach (mb_bits[i]) seq = {seq[6:0], mb_bits[i]};
      checks++;
      if (mb_bits.size() !== 8) begin errors++; $display("FAIL nogap_bit_count got=%0d want=8", mb_bits.size()); end
      checks++;
      if (seq !== 8'b1000_0001) begin errors++; $display("FAIL nogap_mosi_bits got=%b want=10000001", seq); end
   endtask

   task automatic test_reset_mid_word();
      int dc, ne;
      logic b0;
      @(negedge clk);
      ba.word_in = 24'hA5C33C;
      ba.start   = 1'b1;
      @(negedge clk);
      ba.start = 1'b0;
      repeat (15) @(negedge clk);
      checks++;
      if ({ba.spi_transmit, ba.spi_data} !== 9'h1C3) begin
         errors++;
         $display("FAIL midreset_in_second_send got=%h want=1c3", {ba.spi_transmit, ba.spi_data});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({ba.busy, ba.done, ba.err, ba.spi_transmit, ba.spi_clr, ba.spi_data} !== 13'h0) begin
         errors++;
         $display("FAIL midreset_outputs got=%h want=0",
                  {ba.busy, ba.done, ba.err, ba.spi_transmit, ba.spi_clr, ba.spi_data});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ba.busy, ba.done, ba.err} !== 3'b000) begin
         errors++;
         $display("FAIL midreset_abandoned got=%b want=000", {ba.busy, ba.done, ba.err});
      end
      run_a(24'h000001, 1'b0, dc, b0, ne);
      checks++;
      if (dc !== 39) begin errors++; $display("FAIL midreset_rerun_done got=%0d want=39", dc); end
      checks++;
      if (got_word() !== 24'h000001) begin errors++; $display("FAIL midreset_rerun_bytes got=%h want=000001", got_word()); end
      checks++;
      if (ne !== 0) begin errors++; $display("FAIL midreset_rerun_err got=%0d want=0", ne); end
   endtask

   task automatic test_back_to_back();
      int dc, ne;
      logic b0;
      @(negedge clk);
      run_a(24'h3C5AA5, 1'b0, dc, b0, ne);
      checks++;
      if (dc !== 39) begin errors++; $display("FAIL b2b_first_done got=%0d want=39", dc); end
      run_a(24'h0F1E2D, 1'b0, dc, b0, ne);
      checks++;
      if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_done_cycle got=%b want=1", b0); end
      checks++;
      if (dc !== 39) begin errors++; $display("FAIL b2b_second_done got=%0d want=39", dc); end
      checks++;
      if (got_word() !== 24'h0F1E2D) begin errors++; $display("FAIL b2b_second_bytes got=%h want=0f1e2d", got_word()); end
   endtask

   task automatic test_invariants();
      checks++;
      if (mon_viol !== 0) begin errors++; $display("FAIL invariants violations=%0d want=0", mon_viol); end
   endtask

   initial begin
      ba.start = 1'b0; ba.word_in = '0;
      bb.start = 1'b0; bb.word_in = '0;
      test_reset();
      test_basic_word();
      test_start_ignored();
      test_timeout();
      test_single_byte_no_gap();
      test_reset_mid_word();
      test_back_to_back();
      repeat (2) @(negedge clk);
      test_invariants();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
